// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 key decoder: prefix/discard/modifier scan codes,
// prefix FSM encoding and the bit layout of a queued key event.
package ps2_pkg;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;
  localparam logic [7:0] CODE_E1 = 8'hE1;
  localparam logic [7:0] CODE_AA = 8'hAA;
  localparam logic [7:0] CODE_FA = 8'hFA;
  localparam logic [7:0] CODE_FE = 8'hFE;
  localparam logic [7:0] CODE_EE = 8'hEE;
  localparam logic [7:0] CODE_00 = 8'h00;
  localparam logic [7:0] CODE_FF = 8'hFF;

  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CTRL   = 8'h14;
  localparam logic [7:0] CODE_CAPS   = 8'h58;

  // Pause/Break sends E1 followed by seven more bytes that carry no key event.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  localparam int ENTRY_W   = 20;
  localparam int ASCII_LSB = 0;
  localparam int CODE_LSB  = 8;
  localparam int BIT_BRK   = 16;
  localparam int BIT_EXT   = 17;
  localparam int BIT_SHIFT = 18;
  localparam int BIT_CTRL  = 19;

  function automatic logic is_discard(input logic [7:0] code);
    return (code == CODE_AA) || (code == CODE_FA) || (code == CODE_FE) ||
           (code == CODE_EE) || (code == CODE_00) || (code == CODE_FF);
  endfunction

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Combinational set-2 scan code to ASCII translation for non-extended codes.
// Unmapped codes give 8'h00.
module ps2_scan_to_ascii (
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] letter;

  always_comb begin
    ascii  = 8'h00;
    letter = 8'h00;
    case (code)
      8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
      8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
      8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
      8'h16: ascii = shift ? 8'h21 : 8'h31;
      8'h1E: ascii = shift ? 8'h40 : 8'h32;
      8'h26: ascii = shift ? 8'h23 : 8'h33;
      8'h25: ascii = shift ? 8'h24 : 8'h34;
      8'h2E: ascii = shift ? 8'h25 : 8'h35;
      8'h36: ascii = shift ? 8'h5E : 8'h36;
      8'h3D: ascii = shift ? 8'h26 : 8'h37;
      8'h3E: ascii = shift ? 8'h2A : 8'h38;
      8'h46: ascii = shift ? 8'h28 : 8'h39;
      8'h45: ascii = shift ? 8'h29 : 8'h30;
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      8'h66: ascii = 8'h08;
      8'h0D: ascii = 8'h09;
      8'h76: ascii = 8'h1B;
      default: ascii = 8'h00;
    endcase
    // Letters are lowercase in the table; shift and caps cancel each other.
    if (letter != 8'h00) ascii = (shift ^ caps) ? (letter - 8'h20) : letter;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: prefix FSM, modifier tracking, ASCII translation and a
// show-ahead event FIFO read by the CPU.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          i_code,
  input  logic                i_code_valid,
  input  logic                i_rx_error,
  input  logic                i_rd,
  input  logic                i_clr_ovf,
  output logic [ENTRY_W-1:0]  o_rd_data,
  output logic                o_empty,
  output logic                o_full,
  output logic [ADDR_W:0]     o_count,
  output logic                o_overflow,
  output logic                o_irq
);

  state_t state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic shift_q, shift_d, ctrl_q, ctrl_d, caps_q, caps_d;
  logic fin, fin_ext, fin_brk;
  logic is_shift, is_ctrl, is_caps, push_d;
  logic [7:0] ascii;
  logic [ENTRY_W-1:0] entry_d;

  logic                evt_valid_q;
  logic [ENTRY_W-1:0]  evt_q;
  logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     count_q;
  logic                ovf_q;
  logic                full, empty, pop, do_push, ovf_set;

  ps2_scan_to_ascii u_ascii (
    .code  (i_code),
    .shift (shift_q),
    .caps  (caps_q),
    .ascii (ascii)
  );

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    fin     = 1'b0;
    fin_ext = 1'b0;
    fin_brk = 1'b0;
    if (i_rx_error) begin
      state_d = S_IDLE;
    end else if (i_code_valid) begin
      case (state_q)
        S_IDLE: begin
          if (i_code == CODE_E0) state_d = S_EXT;
          else if (i_code == CODE_F0) state_d = S_BRK;
          else if (i_code == CODE_E1) begin
            state_d = S_PAUSE;
            skip_d  = PAUSE_SKIP;
          end else if (!is_discard(i_code)) fin = 1'b1;
        end
        S_EXT: begin
          if (i_code == CODE_F0) state_d = S_EXT_BRK;
          else begin
            fin     = 1'b1;
            fin_ext = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          fin     = 1'b1;
          fin_brk = 1'b1;
          state_d = S_IDLE;
        end
        S_EXT_BRK: begin
          fin     = 1'b1;
          fin_ext = 1'b1;
          fin_brk = 1'b1;
          state_d = S_IDLE;
        end
        S_PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_d == 3'd0) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Modifier keys are absorbed; the queued entry records the state before this event.
  always_comb begin
    is_shift = fin && !fin_ext && ((i_code == CODE_LSHIFT) || (i_code == CODE_RSHIFT));
    is_ctrl  = fin && (i_code == CODE_CTRL);
    is_caps  = fin && !fin_ext && (i_code == CODE_CAPS);
    shift_d  = is_shift ? !fin_brk : shift_q;
    ctrl_d   = is_ctrl ? !fin_brk : ctrl_q;
    caps_d   = (is_caps && !fin_brk) ? !caps_q : caps_q;
    push_d   = fin && !is_shift && !is_ctrl && !is_caps;
    entry_d  = '0;
    entry_d[BIT_CTRL]             = ctrl_q;
    entry_d[BIT_SHIFT]            = shift_q;
    entry_d[BIT_EXT]              = fin_ext;
    entry_d[BIT_BRK]              = fin_brk;
    entry_d[CODE_LSB +: 8]        = i_code;
    entry_d[ASCII_LSB +: 8]       = fin_ext ? 8'h00 : ascii;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      skip_q      <= 3'd0;
      shift_q     <= 1'b0;
      ctrl_q      <= 1'b0;
      caps_q      <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_q       <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      shift_q     <= shift_d;
      ctrl_q      <= ctrl_d;
      caps_q      <= caps_d;
      evt_valid_q <= push_d;
      evt_q       <= entry_d;
    end
  end

  assign full    = (count_q == (ADDR_W+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = i_rd && !empty;
  assign do_push = evt_valid_q && (!full || pop);
  assign ovf_set = evt_valid_q && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= evt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !pop) count_q <= count_q + 1'b1;
      else if (pop && !do_push) count_q <= count_q - 1'b1;
      if (ovf_set) ovf_q <= 1'b1;
      else if (i_clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign o_rd_data  = empty ? '0 : mem[rd_ptr_q];
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;
  assign o_irq      = !empty;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a table of single scan codes with expected
// queued entries, plus hand-written error, reset and FIFO boundary sequences.
module tb_ps2_key_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_code;
  logic        i_code_valid;
  logic        i_rx_error;
  logic        i_rd;
  logic        i_clr_ovf;
  logic [19:0] o_rd_data;
  logic        o_empty;
  logic        o_full;
  logic [3:0]  o_count;
  logic        o_overflow;
  logic        o_irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  code;
    logic        has;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [19:0] exp_q[$];

  ps2_key_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .i_code       (i_code),
    .i_code_valid (i_code_valid),
    .i_rx_error   (i_rx_error),
    .i_rd         (i_rd),
    .i_clr_ovf    (i_clr_ovf),
    .o_rd_data    (o_rd_data),
    .o_empty      (o_empty),
    .o_full       (o_full),
    .o_count      (o_count),
    .o_overflow   (o_overflow),
    .o_irq        (o_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Code strobes on edge N; rd/clr are held across edge N+1 (the FIFO write edge).
  task automatic send(input logic [7:0] code, input logic rd, input logic clr);
    @(negedge clk);
    i_code = code;
    i_code_valid = 1'b1;
    @(negedge clk);
    i_code_valid = 1'b0;
    i_rd = rd;
    i_clr_ovf = clr;
    @(negedge clk);
    i_rd = 1'b0;
    i_clr_ovf = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    i_rd = 1'b1;
    @(negedge clk);
    i_rd = 1'b0;
  endtask

  task automatic clr_ovf();
    @(negedge clk);
    i_clr_ovf = 1'b1;
    @(negedge clk);
    i_clr_ovf = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic expect_entry(input string name, input logic [19:0] exp);
    chk({name, "_empty"}, 32'(o_empty), 32'd0);
    chk({name, "_data"}, 32'(o_rd_data), 32'(exp));
    pop();
    chk({name, "_popped"}, 32'(o_empty), 32'd1);
  endtask

  function automatic vec_t v(input logic [7:0] c, input logic h, input logic [19:0] e);
    vec_t r;
    r.code = c;
    r.has  = h;
    r.exp  = e;
    return r;
  endfunction

  initial begin
    reset = 1'b1;
    i_code = 8'h00;
    i_code_valid = 1'b0;
    i_rx_error = 1'b0;
    i_rd = 1'b0;
    i_clr_ovf = 1'b0;

    vecs.push_back(v(8'h1C, 1, 20'h01C61));
    vecs.push_back(v(8'h12, 0, 0));
    vecs.push_back(v(8'h1C, 1, 20'h41C41));
    vecs.push_back(v(8'hF0, 0, 0));
    vecs.push_back(v(8'h1C, 1, 20'h51C41));
    vecs.push_back(v(8'hF0, 0, 0));
    vecs.push_back(v(8'h12, 0, 0));
    vecs.push_back(v(8'h1C, 1, 20'h01C61));
    vecs.push_back(v(8'h58, 0, 0));
    vecs.push_back(v(8'h16, 1, 20'h01631));
    vecs.push_back(v(8'h1C, 1, 20'h01C41));
    vecs.push_back(v(8'h12, 0, 0));
    vecs.push_back(v(8'h1C, 1, 20'h41C61));
    vecs.push_back(v(8'h58, 0, 0));
    vecs.push_back(v(8'h16, 1, 20'h41621));
    vecs.push_back(v(8'h45, 1, 20'h44529));
    vecs.push_back(v(8'hF0, 0, 0));
    vecs.push_back(v(8'h59, 0, 0));
    vecs.push_back(v(8'h29, 1, 20'h02920));
    vecs.push_back(v(8'h14, 0, 0));
    vecs.push_back(v(8'h5A, 1, 20'h85A0D));
    vecs.push_back(v(8'hE0, 0, 0));
    vecs.push_back(v(8'hF0, 0, 0));
    vecs.push_back(v(8'h14, 0, 0));
    vecs.push_back(v(8'h66, 1, 20'h06608));
    vecs.push_back(v(8'hE0, 0, 0));
    vecs.push_back(v(8'h74, 1, 20'h27400));
    vecs.push_back(v(8'hE0, 0, 0));
    vecs.push_back(v(8'hF0, 0, 0));
    vecs.push_back(v(8'h74, 1, 20'h37400));
    vecs.push_back(v(8'hAA, 0, 0));
    vecs.push_back(v(8'hFA, 0, 0));
    vecs.push_back(v(8'h00, 0, 0));
    vecs.push_back(v(8'hE1, 0, 0));
    vecs.push_back(v(8'h14, 0, 0));
    vecs.push_back(v(8'h77, 0, 0));
    vecs.push_back(v(8'hE1, 0, 0));
    vecs.push_back(v(8'hF0, 0, 0));
    vecs.push_back(v(8'h14, 0, 0));
    vecs.push_back(v(8'hF0, 0, 0));
    vecs.push_back(v(8'h77, 0, 0));
    vecs.push_back(v(8'h76, 1, 20'h0761B));
    vecs.push_back(v(8'h0D, 1, 20'h00D09));
    vecs.push_back(v(8'h3E, 1, 20'h03E38));
    vecs.push_back(v(8'hF0, 0, 0));
    vecs.push_back(v(8'h58, 0, 0));
    vecs.push_back(v(8'h15, 1, 20'h01571));

    // Reset state
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_irq", 32'(o_irq), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_data", 32'(o_rd_data), 32'd0);

    // Latency: nothing visible after edge N, entry visible after edge N+1
    @(negedge clk);
    i_code = 8'h1C;
    i_code_valid = 1'b1;
    @(negedge clk);
    i_code_valid = 1'b0;
    chk("lat_n_empty", 32'(o_empty), 32'd1);
    @(negedge clk);
    chk("lat_n1_irq", 32'(o_irq), 32'd1);
    chk("lat_n1_count", 32'(o_count), 32'd1);
    expect_entry("lat_entry", 20'h01C61);

    // Table-driven scan code stream
    foreach (vecs[i]) begin
      send(vecs[i].code, 1'b0, 1'b0);
      if (vecs[i].has) expect_entry($sformatf("vec%0d", i), vecs[i].exp);
      else chk($sformatf("vec%0d_none", i), 32'(o_empty), 32'd1);
    end

    // Receiver error between E0 and 74 drops the extended prefix
    send(8'hE0, 1'b0, 1'b0);
    @(negedge clk);
    i_rx_error = 1'b1;
    @(negedge clk);
    i_rx_error = 1'b0;
    send(8'h74, 1'b0, 1'b0);
    expect_entry("err_mid", 20'h07400);

    // Error wins over a simultaneous code
    send(8'hF0, 1'b0, 1'b0);
    @(negedge clk);
    i_code = 8'h1C;
    i_code_valid = 1'b1;
    i_rx_error = 1'b1;
    @(negedge clk);
    i_code_valid = 1'b0;
    i_rx_error = 1'b0;
    @(negedge clk);
    chk("err_prio_none", 32'(o_empty), 32'd1);
    send(8'h1C, 1'b0, 1'b0);
    expect_entry("err_prio_next", 20'h01C61);

    // Reset mid break prefix
    send(8'hF0, 1'b0, 1'b0);
    do_reset();
    send(8'h1C, 1'b0, 1'b0);
    expect_entry("rst_mid", 20'h01C61);

    // Pop while empty is ignored
    pop();
    chk("pop_empty_count", 32'(o_count), 32'd0);

    // Fill the FIFO, then overflow
    send(8'h1C, 0, 0); exp_q.push_back(20'h01C61);
    send(8'h32, 0, 0); exp_q.push_back(20'h03262);
    send(8'h21, 0, 0); exp_q.push_back(20'h02163);
    send(8'h23, 0, 0); exp_q.push_back(20'h02364);
    send(8'h24, 0, 0); exp_q.push_back(20'h02465);
    send(8'h2B, 0, 0); exp_q.push_back(20'h02B66);
    send(8'h34, 0, 0); exp_q.push_back(20'h03467);
    send(8'h33, 0, 0); exp_q.push_back(20'h03368);
    chk("fill_count", 32'(o_count), 32'd8);
    chk("fill_full", 32'(o_full), 32'd1);
    chk("fill_ovf", 32'(o_overflow), 32'd0);
    send(8'h43, 1'b0, 1'b0);
    chk("ovf_set", 32'(o_overflow), 32'd1);
    chk("ovf_count", 32'(o_count), 32'd8);
    clr_ovf();
    chk("ovf_clr", 32'(o_overflow), 32'd0);
    send(8'h43, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(o_overflow), 32'd1);
    clr_ovf();
    chk("ovf_clr2", 32'(o_overflow), 32'd0);

    // Push and pop together while full
    send(8'h4B, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    exp_q.push_back(20'h04B6C);
    chk("full_pp_ovf", 32'(o_overflow), 32'd0);
    chk("full_pp_count", 32'(o_count), 32'd8);
    while (exp_q.size() > 0) begin
      logic [19:0] e;
      e = exp_q.pop_front();
      chk("drain_data", 32'(o_rd_data), 32'(e));
      pop();
    end
    chk("drain_empty", 32'(o_empty), 32'd1);
    chk("drain_count", 32'(o_count), 32'd0);

    // Push and pop together while empty: push occurs, pop ignored
    send(8'h4D, 1'b1, 1'b0);
    chk("empty_pp_count", 32'(o_count), 32'd1);
    expect_entry("empty_pp", 20'h04D70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
